// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port 1-cycle-latency on-chip RAM.
// Round-robin by default; define ONCHIP_MEM_ARB_FIXED_PRIO_EN for master-0 fixed priority.
//
// Handshake: a master presents read/write and holds its command while waitrequest=1;
// the command is accepted in the cycle waitrequest=0 and read data returns exactly one
// cycle later with readdatavalid=1 on that same master. The RAM side has no backpressure.
module onchip_mem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        last_grant, last_grant_next;
  logic        force_other, force_other_next;
  logic [7:0]  lock_cnt, lock_cnt_next;
  logic [7:0]  lock_cnt_inc;
  logic        rd_pend, rd_src;

  logic        req0, req1;
  logic        gnt_valid, gnt_sel;
  logic        prio_pick, contend_pick;
  logic        sel_write, sel_lock, issue_read;
  logic [ADDR_W-1:0] sel_address;
  logic [BE_W-1:0]   sel_byteenable;
  logic [DATA_W-1:0] sel_writedata;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef ONCHIP_MEM_ARB_FIXED_PRIO_EN
  assign prio_pick = 1'b0;
`else
  assign prio_pick = ~last_grant;
`endif

  // force_other is set only by a MAX_LOCK exit and hands the next contention to the other master.
  assign contend_pick = force_other ? ~last_grant : prio_pick;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_sel   = 1'b0;
    if (!reset) begin
      case (state)
        ARB: begin
          if (req0 && req1) begin
            gnt_valid = 1'b1;
            gnt_sel   = contend_pick;
          end else if (req0) begin
            gnt_valid = 1'b1;
            gnt_sel   = 1'b0;
          end else if (req1) begin
            gnt_valid = 1'b1;
            gnt_sel   = 1'b1;
          end
        end
        // While locked the other master is stalled even if the owner is idle this cycle.
        LOCK0: begin
          gnt_valid = req0;
          gnt_sel   = 1'b0;
        end
        LOCK1: begin
          gnt_valid = req1;
          gnt_sel   = 1'b1;
        end
        default: begin
          gnt_valid = 1'b0;
          gnt_sel   = 1'b0;
        end
      endcase
    end
  end

  assign sel_write      = gnt_sel ? m1_write      : m0_write;
  assign sel_lock       = gnt_sel ? m1_lock       : m0_lock;
  assign sel_address    = gnt_sel ? m1_address    : m0_address;
  assign sel_byteenable = gnt_sel ? m1_byteenable : m0_byteenable;
  assign sel_writedata  = gnt_sel ? m1_writedata  : m0_writedata;

  // A granted request without write is a read; write wins when both are raised.
  assign issue_read = gnt_valid & ~sel_write;

  assign mem_chipselect = gnt_valid;
  assign mem_write      = gnt_valid & sel_write;
  assign mem_address    = gnt_valid ? sel_address    : '0;
  assign mem_byteenable = gnt_valid ? sel_byteenable : '0;
  assign mem_writedata  = gnt_valid ? sel_writedata  : '0;
  assign mem_clken      = ~reset;

  assign m0_waitrequest = ~(gnt_valid & ~gnt_sel);
  assign m1_waitrequest = ~(gnt_valid &  gnt_sel);

  assign m0_readdatavalid = rd_pend & ~rd_src;
  assign m1_readdatavalid = rd_pend &  rd_src;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

  assign lock_cnt_inc = lock_cnt + 8'd1;

  always_comb begin
    state_next       = state;
    lock_cnt_next    = lock_cnt;
    force_other_next = force_other;
    last_grant_next  = gnt_valid ? gnt_sel : last_grant;
    case (state)
      ARB: begin
        if (gnt_valid) begin
          force_other_next = 1'b0;
          if (sel_lock) begin
            lock_cnt_next = 8'd1;
            // A one-access lock is already exhausted by the access that requested it.
            if (MAX_LOCK_C <= 8'd1) begin
              force_other_next = 1'b1;
            end else begin
              state_next = gnt_sel ? LOCK1 : LOCK0;
            end
          end
        end
      end
      LOCK0, LOCK1: begin
        if (!gnt_valid) begin
          state_next = ARB;
        end else begin
          lock_cnt_next = lock_cnt_inc;
          if (!sel_lock) begin
            state_next = ARB;
          end else if (lock_cnt_inc >= MAX_LOCK_C) begin
            state_next       = ARB;
            force_other_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = ARB;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ARB;
      last_grant  <= 1'b1;
      force_other <= 1'b0;
      lock_cnt    <= 8'd0;
      rd_pend     <= 1'b0;
      rd_src      <= 1'b0;
    end else begin
      state       <= state_next;
      last_grant  <= last_grant_next;
      force_other <= force_other_next;
      lock_cnt    <= lock_cnt_next;
      rd_pend     <= issue_read;
      rd_src      <= gnt_sel;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level arbitration/memory model; read returns go through a scoreboard queue.
module tb_onchip_mem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic          m_rd [2];
  logic          m_wr [2];
  logic          m_lk [2];
  logic [AW-1:0] m_addr [2];
  logic [BW-1:0] m_be [2];
  logic [DW-1:0] m_data [2];

  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata = '0;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m_addr[0]), .m0_byteenable(m_be[0]), .m0_read(m_rd[0]),
    .m0_write(m_wr[0]), .m0_writedata(m_data[0]), .m0_lock(m_lk[0]),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m_addr[1]), .m1_byteenable(m_be[1]), .m1_read(m_rd[1]),
    .m1_write(m_wr[1]), .m1_writedata(m_data[1]), .m1_lock(m_lk[1]),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // Behavioural single-port RAM with one-cycle read latency.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  int  own = -1;
  int  run = 0;
  int  last = 1;
  bit  owed = 1'b0;
  int  obs_g = -1;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic model_reset();
    own = -1; run = 0; last = 1; owed = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  function automatic int model_grant();
    bit r0, r1;
    r0 = m_rd[0] | m_wr[0];
    r1 = m_rd[1] | m_wr[1];
    if (own >= 0) return (own == 0 ? r0 : r1) ? own : -1;
    if (r0 && r1) begin
      if (owed) return 1 - last;
`ifdef ONCHIP_MEM_ARB_FIXED_PRIO_EN
      return 0;
`else
      return 1 - last;
`endif
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_update(input int g);
    if (own >= 0) begin
      if (g < 0) own = -1;
      else begin
        run++;
        if (!m_lk[g]) own = -1;
        else if (run >= ML) begin own = -1; owed = 1'b1; end
      end
    end else if (g >= 0) begin
      owed = 1'b0;
      if (m_lk[g]) begin
        if (ML <= 1) owed = 1'b1;
        else begin own = g; run = 1; end
      end
    end
    if (g >= 0) last = g;
  endtask

  // Compare the issue side of this cycle and record the expected read return.
  task automatic check_cycle();
    int g;
    logic [DW-1:0] v;
    g = reset ? -1 : model_grant();
    obs_g = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : -1);
    chk("wait0", m0_waitrequest, g != 0);
    chk("wait1", m1_waitrequest, g != 1);
    chk("chipselect", mem_chipselect, g >= 0);
    chk("clken", mem_clken, !reset);
    if (g >= 0) begin
      chk("mem_write", mem_write, m_wr[g]);
      chk("mem_address", mem_address, m_addr[g]);
      chk("mem_byteenable", mem_byteenable, m_be[g]);
      chk("mem_writedata", mem_writedata, m_data[g]);
      if (m_wr[g]) begin
        v = ref_read(int'(m_addr[g]));
        for (int b = 0; b < BW; b++)
          if (m_be[g][b]) v[8*b +: 8] = m_data[g][8*b +: 8];
        ref_mem[int'(m_addr[g])] = v;
      end else if (g == 0) exp_q0.push_back(ref_read(int'(m_addr[0])));
      else exp_q1.push_back(ref_read(int'(m_addr[1])));
    end else begin
      chk("mem_idle", {mem_write, mem_address, mem_byteenable, mem_writedata}, '0);
    end
    if (!reset) model_update(g);
  endtask

  // Read-return monitor, sampled well after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q0.size() != 0) begin
        chk("rdvalid0", m0_readdatavalid, 1'b1);
        chk("rdata0", m0_readdata, exp_q0.pop_front());
      end else chk("rd_idle0", {m0_readdatavalid, m0_readdata}, '0);
      if (exp_q1.size() != 0) begin
        chk("rdvalid1", m1_readdatavalid, 1'b1);
        chk("rdata1", m1_readdata, exp_q1.pop_front());
      end else chk("rd_idle1", {m1_readdatavalid, m1_readdata}, '0);
    end
  end

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int m, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] d, input bit lk);
    m_rd[m] = rd; m_wr[m] = wr; m_addr[m] = a; m_be[m] = be; m_data[m] = d; m_lk[m] = lk;
  endtask

  task automatic idle(input int m);
    set_cmd(m, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic rand_cmd(input int m);
    int r;
    logic [AW-1:0] a;
    r = $urandom_range(0, 9);
    a = ($urandom_range(0, 3) == 0) ? AW'(14'h3FFF) : AW'($urandom_range(0, 15));
    set_cmd(m, r >= 4 && r != 7 && r != 8, r >= 7, a, BW'($urandom_range(0, 15)),
            $urandom, $urandom_range(0, 3) == 0);
    if (r < 4) idle(m);
  endtask

  task automatic run_seq(input string name, input int exp_seq[$]);
    foreach (exp_seq[i]) begin
      step();
      chk($sformatf("%s_%0d", name, i), obs_g, exp_seq[i]);
    end
  endtask

  initial begin
    int exp_seq[$];
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    idle(0);
    idle(1);
    repeat (2) step();
    reset = 1'b0;
    repeat (2) step();

    // Reset pulse in the middle of a cycle with both masters idle.
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_outputs", {m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
                        mem_chipselect, mem_write, mem_clken}, 7'b1100000);
    step();
    reset = 1'b0;
    step();
    chk("clken_after_rst", mem_clken, 1'b1);

    // Full write, read back, then a single-byte write from master 1.
    set_cmd(0, 1'b0, 1'b1, 14'h0010, 4'hF, 32'hDEADBEEF, 1'b0);
    step();
    chk("wr0_grant", obs_g, 0);
    set_cmd(0, 1'b1, 1'b0, 14'h0010, 4'hF, '0, 1'b0);
    step();
    chk("rd0_grant", obs_g, 0);
    idle(0);
    chk("rd0_valid", m0_readdatavalid, 1'b1);
    chk("rd0_data", m0_readdata, 32'hDEADBEEF);
    set_cmd(1, 1'b0, 1'b1, 14'h0010, 4'h2, 32'h0000AA00, 1'b0);
    step();
    idle(1);
    set_cmd(0, 1'b1, 1'b0, 14'h0010, 4'hF, '0, 1'b0);
    step();
    idle(0);
    chk("merge_valid", m0_readdatavalid, 1'b1);
    chk("merge_data", m0_readdata, 32'hDEADAAEF);

    // Seed distinct data; the last access is from master 1.
    for (int i = 0; i < 6; i++) begin
      set_cmd(0, 1'b0, 1'b1, AW'(32 + i), 4'hF, $urandom, 1'b0);
      step();
      idle(0);
      set_cmd(1, 1'b0, 1'b1, AW'(48 + i), 4'hF, $urandom, 1'b0);
      step();
      idle(1);
    end

    // Continuous reads from both masters.
    set_cmd(0, 1'b1, 1'b0, 14'h0020, 4'hF, '0, 1'b0);
    set_cmd(1, 1'b1, 1'b0, 14'h0030, 4'hF, '0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
`ifdef ONCHIP_MEM_ARB_FIXED_PRIO_EN
      chk($sformatf("contend_%0d", i), obs_g, 0);
`else
      chk($sformatf("contend_%0d", i), obs_g, i % 2);
`endif
      if (obs_g >= 0) m_addr[obs_g] = m_addr[obs_g] + 1'b1;
    end
    idle(0);
    idle(1);
    step();

    // Master 1 locked: four grants, then master 0.
    set_cmd(1, 1'b1, 1'b0, 14'h0030, 4'hF, '0, 1'b1);
    step();
    chk("lock1_first", obs_g, 1);
    set_cmd(0, 1'b1, 1'b0, 14'h0020, 4'hF, '0, 1'b0);
    exp_seq = '{1, 1, 1, 0};
    run_seq("lock1", exp_seq);
    idle(0);
    idle(1);
    step();

    // Master 0 locked: after MAX_LOCK the waiting master 1 must be served.
    set_cmd(0, 1'b1, 1'b0, 14'h0021, 4'hF, '0, 1'b1);
    step();
    chk("lock0_first", obs_g, 0);
    set_cmd(1, 1'b1, 1'b0, 14'h0031, 4'hF, '0, 1'b0);
    exp_seq = '{0, 0, 0, 1};
    run_seq("lock0", exp_seq);
    idle(0);
    idle(1);
    step();

    // Random traffic; masters hold their command until accepted.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int m = 0; m < 2; m++)
        if (!(m_rd[m] | m_wr[m]) || obs_g == m) rand_cmd(m);
      step();
    end
    idle(0);
    idle(1);
    repeat (ML + 2) step();

    // Reset lands while a read return is on the bus.
    set_cmd(0, 1'b1, 1'b0, 14'h0010, 4'hF, '0, 1'b0);
    step();
    idle(0);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_drop_valid", m0_readdatavalid, 1'b0);
    chk("rst_drop_data", m0_readdata, '0);
    step();
    reset = 1'b0;
    set_cmd(0, 1'b1, 1'b0, 14'h0010, 4'hF, '0, 1'b0);
    set_cmd(1, 1'b1, 1'b0, 14'h0030, 4'hF, '0, 1'b0);
    step();
    chk("post_rst_contend", obs_g, 0);
    idle(0);
    idle(1);
    repeat (3) step();

    chk("drain0", exp_q0.size(), 0);
    chk("drain1", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
